// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes (also used by tmds_encoder_dvi)
// and the receiver word-alignment state enum.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch,
    StSlipWait,
    StVerify,
    StLocked
  } align_state_e;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: classifies control tokens and undoes the
// XOR/XNOR transition-minimising encoding for data words.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] tmds,
  output logic       is_ctrl,
  output logic [1:0] ctl,
  output logic [7:0] data_8bit
);

  logic [7:0] d;

  always_comb begin
    is_ctrl = 1'b1;
    ctl     = 2'b00;
    case (tmds)
      CTRL_TOKEN_00: ctl = 2'b00;
      CTRL_TOKEN_01: ctl = 2'b01;
      CTRL_TOKEN_10: ctl = 2'b10;
      CTRL_TOKEN_11: ctl = 2'b11;
      default:       is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    d            = tmds[9] ? ~tmds[7:0] : tmds[7:0];
    data_8bit    = 8'h00;
    data_8bit[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data_8bit[i] = tmds[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder_dvi_rx.sv
// TMDS receive channel: word decode, bitslip-driven word alignment FSM and
// registered pixel/control outputs (zeroed whenever the channel is not locked).
module tmds_decoder_dvi_rx
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_WINDOW = 8192,
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SLIP_WAIT     = 4
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds,
  output logic [7:0] data_8bit,
  output logic [1:0] ctl,
  output logic       de,
  output logic       locked,
  output logic       bitslip
);

  localparam int unsigned WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  logic       is_ctrl;
  logic [1:0] dec_ctl;
  logic [7:0] dec_data;

  tmds_word_decode u_word_decode (
    .tmds      (tmds),
    .is_ctrl   (is_ctrl),
    .ctl       (dec_ctl),
    .data_8bit (dec_data)
  );

  align_state_e      state_q, state_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bitslip_d;
  logic [WIN_W-1:0]  win_inc;

  // Saturating so a data word leaving VERIFY cannot push the window past its end.
  assign win_inc = (win_cnt_q >= WIN_LAST) ? win_cnt_q : win_cnt_q + WIN_W'(1);

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    run_cnt_d  = run_cnt_q;
    wait_cnt_d = wait_cnt_q;
    bitslip_d  = 1'b0;
    case (state_q)
      StSearch: begin
        if (is_ctrl) begin
          state_d   = StVerify;
          run_cnt_d = RUN_W'(1);
        end else if (win_cnt_q >= WIN_LAST) begin
          state_d    = StSlipWait;
          bitslip_d  = 1'b1;
          win_cnt_d  = '0;
          wait_cnt_d = '0;
        end else begin
          win_cnt_d = win_inc;
        end
      end
      StSlipWait: begin
        if (wait_cnt_q >= WAIT_LAST) begin
          state_d    = StSearch;
          wait_cnt_d = '0;
          win_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      StVerify: begin
        if (is_ctrl) begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
          if (run_cnt_q >= RUN_LAST) begin
            state_d   = StLocked;
            win_cnt_d = '0;
          end
        end else begin
          state_d   = StSearch;
          run_cnt_d = '0;
          win_cnt_d = win_inc;
        end
      end
      StLocked: begin
        if (is_ctrl) begin
          win_cnt_d = '0;
        end else if (win_cnt_q >= WIN_LAST) begin
          state_d   = StSearch;
          win_cnt_d = '0;
          run_cnt_d = '0;
        end else begin
          win_cnt_d = win_inc;
        end
      end
      default: begin
        state_d    = StSearch;
        win_cnt_d  = '0;
        run_cnt_d  = '0;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q    <= StSearch;
      win_cnt_q  <= '0;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      de         <= 1'b0;
      ctl        <= 2'b00;
      data_8bit  <= 8'h00;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      run_cnt_q  <= run_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      bitslip    <= bitslip_d;
      locked     <= (state_d == StLocked);
      // Outputs follow the next state so the locking token itself is decoded.
      de         <= (state_d == StLocked) && !is_ctrl;
      ctl        <= ((state_d == StLocked) && is_ctrl) ? dec_ctl : 2'b00;
      data_8bit  <= ((state_d == StLocked) && !is_ctrl) ? dec_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_tmds_decoder_dvi_rx.sv
// Directed bench for tmds_decoder_dvi_rx with small alignment parameters.
module tb_tmds_decoder_dvi_rx;

  localparam int unsigned SEARCH_WINDOW = 64;
  localparam int unsigned CTRL_RUN      = 8;
  localparam int unsigned SLIP_WAIT     = 4;

  localparam logic [9:0] TOK00    = 10'b1101010100;
  localparam logic [9:0] TOK01    = 10'b0010101011;
  localparam logic [9:0] MISALIGN = 10'b1010101001;
  localparam logic [9:0] DATA_00  = 10'b0100000000;
  localparam logic [9:0] DATA_FF  = 10'b1000000000;

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic [9:0] tmds      = 10'd0;
  logic [7:0] data_8bit;
  logic [1:0] ctl;
  logic       de;
  logic       locked;
  logic       bitslip;

  int checks = 0;
  int errors = 0;
  int slip_count = 0;
  int slip_base;

  tmds_decoder_dvi_rx #(
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .CTRL_RUN      (CTRL_RUN),
    .SLIP_WAIT     (SLIP_WAIT)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .tmds      (tmds),
    .data_8bit (data_8bit),
    .ctl       (ctl),
    .de        (de),
    .locked    (locked),
    .bitslip   (bitslip)
  );

  always #5 clk_pixel = ~clk_pixel;

  always @(negedge clk_pixel) if (bitslip) slip_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word, then step to just after the edge that registers it.
  task automatic apply(input logic [9:0] w);
    tmds = w;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tmds  = 10'd0;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 8; i++) apply(TOK00);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_data", data_8bit, 8'h00);
    chk("rst_ctl", ctl, 2'b00);
    chk("rst_de", de, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_bitslip", bitslip, 1'b0);
    do_reset();

    // Lock on eight consecutive tokens
    slip_base = slip_count;
    for (int i = 0; i < 7; i++) apply(TOK00);
    chk("lock_after7", locked, 1'b0);
    apply(TOK00);
    chk("lock_after8", locked, 1'b1);
    chk("lock_de", de, 1'b0);
    chk("lock_ctl", ctl, 2'b00);
    chk("lock_no_slip", slip_count - slip_base, 0);

    // Data and control decode while locked
    apply(DATA_00);
    chk("dec00_data", data_8bit, 8'h00);
    chk("dec00_de", de, 1'b1);
    apply(DATA_FF);
    chk("decff_data", data_8bit, 8'hff);
    chk("decff_de", de, 1'b1);
    apply(TOK01);
    chk("tok01_de", de, 1'b0);
    chk("tok01_ctl", ctl, 2'b01);
    chk("tok01_data", data_8bit, 8'h00);

    // Token in the expiry cycle keeps lock
    for (int i = 0; i < 63; i++) apply(DATA_FF);
    chk("win63_locked", locked, 1'b1);
    apply(TOK00);
    chk("expiry_tok_locked", locked, 1'b1);

    // Full window of data drops lock
    for (int i = 0; i < 63; i++) apply(DATA_FF);
    chk("loss_pre_locked", locked, 1'b1);
    chk("loss_pre_data", data_8bit, 8'hff);
    chk("loss_pre_de", de, 1'b1);
    apply(DATA_FF);
    chk("loss_locked", locked, 1'b0);
    chk("loss_de", de, 1'b0);
    chk("loss_data", data_8bit, 8'h00);
    chk("loss_no_slip", slip_count - slip_base, 0);

    // Broken run restarts the token count
    do_reset();
    slip_base = slip_count;
    for (int i = 0; i < 5; i++) apply(TOK00);
    apply(DATA_00);
    chk("run_break_locked", locked, 1'b0);
    for (int i = 0; i < 7; i++) apply(TOK00);
    chk("run2_after7", locked, 1'b0);
    apply(TOK00);
    chk("run2_after8", locked, 1'b1);
    chk("run2_no_slip", slip_count - slip_base, 0);

    // Misaligned stream: slips at word 64 and 132 only
    do_reset();
    for (int i = 1; i <= 140; i++) begin
      apply(MISALIGN);
      chk($sformatf("slip_w%0d", i), bitslip, (i == 64 || i == 132) ? 1'b1 : 1'b0);
      chk($sformatf("slip_locked_w%0d", i), locked, 1'b0);
    end

    // Asynchronous reset mid-LOCKED
    do_reset();
    lock_up();
    apply(DATA_FF);
    chk("pre_async_de", de, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_data", data_8bit, 8'h00);
    chk("async_de", de, 1'b0);
    chk("async_ctl", ctl, 2'b00);
    chk("async_locked", locked, 1'b0);
    chk("async_bitslip", bitslip, 1'b0);
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
